// File: rtl/busif_pkg.sv
// Shared types and constants for the MCS I/O bus interface.
package busif_pkg;

    // Transaction sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } busif_state_t;

    // Error status codes reported on ERR_CODE.
    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_TMO   = 2'b01;
    localparam logic [1:0] ERR_UNMAP = 2'b10;

    // Default bank numbering used by the camera system.
    localparam int CELLRAM = 0;
    localparam int MEMMODE = 1;
    localparam int LEDBANK = 2;
    localparam int PS2BANK = 3;
    localparam int VGABANK = 4;
    localparam int GRAPH   = 5;
    localparam int CAMPIC  = 6;
    localparam int CAMCTRL = 7;

endpackage

// File: rtl/busif_rdmux.sv
// Registered NBANK-to-1 read data multiplexer with error/zero override.
module busif_rdmux
    import busif_pkg::*;
#(
    parameter int              NBANK     = 8,
    parameter int              BANK_BITS = 4,
    parameter int              DW        = 32,
    parameter logic [DW-1:0]   ERR_DATA  = 32'hDEAD_BEEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  ld,
    input  logic [BANK_BITS-1:0]  sel,
    input  logic                  use_err,
    input  logic                  use_zero,
    input  logic [NBANK*DW-1:0]   rdata,
    output logic [DW-1:0]         dout
);

    logic [DW-1:0] mux_d;
    logic [DW-1:0] nxt_d;

    // Select the addressed bank; zero takes priority over the error pattern.
    always_comb begin
        mux_d = '0;
        for (int b = 0; b < NBANK; b++) begin
            if (sel == BANK_BITS'(b)) begin
                mux_d = rdata[b*DW +: DW];
            end
        end
        if (use_zero) begin
            nxt_d = '0;
        end else if (use_err) begin
            nxt_d = ERR_DATA;
        end else begin
            nxt_d = mux_d;
        end
    end

    // Hold the returned data until the next load.
    always_ff @(posedge CLK) begin
        if (RST) begin
            dout <= '0;
        end else if (ld) begin
            dout <= nxt_d;
        end
    end

endmodule

// File: rtl/busif_gen.sv
// MCS I/O bus interface: bank decode, wait-state handshake, timeout and
// sticky error status.
//
// Handshake: a transaction starts when IO_Addr_Strobe is high in IDLE with
// exactly one of IO_Read_Strobe/IO_Write_Strobe. The bank sees a single-cycle
// WR/RD strobe; wait banks answer with BANK_RDY (level, sampled every WAIT
// cycle), other banks are assumed to answer within the strobe cycle. The MCS
// sees IO_Ready for exactly one cycle, with IO_Read_Data valid in that cycle
// and held until the next completion. No back-pressure exists toward the MCS.
module busif_gen
    import busif_pkg::*;
#(
    parameter int                NBANK     = 8,
    parameter int                BANK_BITS = 4,
    parameter int                BANK_LSB  = 16,
    parameter int                DW        = 32,
    parameter logic [NBANK-1:0]  WAITMASK  = 8'b0000_0001,
    parameter int                TIMEOUT   = 1023,
    parameter logic [DW-1:0]     ERR_DATA  = 32'hDEAD_BEEF
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [31:0]           IO_Address,
    input  logic                  IO_Addr_Strobe,
    input  logic                  IO_Read_Strobe,
    input  logic                  IO_Write_Strobe,
    output logic                  IO_Ready,
    output logic [DW-1:0]         IO_Read_Data,
    output logic [NBANK-1:0]      WR,
    output logic [NBANK-1:0]      RD,
    input  logic [NBANK*DW-1:0]   RDATA,
    input  logic [NBANK-1:0]      BANK_RDY,
    input  logic                  ERR_CLR,
    output logic                  ERR,
    output logic [1:0]            ERR_CODE,
    output logic [BANK_BITS-1:0]  ERR_BANK,
    output logic                  BUSY,
    output logic [1:0]            DBG_STATE
);

    localparam int CW = $clog2(TIMEOUT + 1);

    busif_state_t          state, state_nxt;
    logic [BANK_BITS-1:0]  bank_q;
    logic                  dir_wr_q;
    logic [CW-1:0]         cnt;

    logic                  latch;
    logic                  ld;
    logic                  use_err;
    logic                  use_zero;
    logic                  err_ev;
    logic [1:0]            err_code_ev;
    logic                  cnt_clr;
    logic                  cnt_inc;

    logic                  bank_mapped;
    logic                  sel_wait;
    logic                  sel_rdy;

    // Out-of-range bank numbers are compared one bit wider so NBANK=2**BANK_BITS works.
    assign bank_mapped = ({1'b0, bank_q} < (BANK_BITS+1)'(NBANK));

    // Look up wait policy and ready line of the latched bank; unmapped banks read as 0.
    always_comb begin
        sel_wait = 1'b0;
        sel_rdy  = 1'b0;
        for (int b = 0; b < NBANK; b++) begin
            if (bank_q == BANK_BITS'(b)) begin
                sel_wait = WAITMASK[b];
                sel_rdy  = BANK_RDY[b];
            end
        end
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and per-state control strobes.
    always_comb begin
        state_nxt   = state;
        latch       = 1'b0;
        ld          = 1'b0;
        use_err     = 1'b0;
        use_zero    = 1'b0;
        err_ev      = 1'b0;
        err_code_ev = ERR_NONE;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        WR          = '0;
        RD          = '0;
        IO_Ready    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (IO_Addr_Strobe && (IO_Read_Strobe ^ IO_Write_Strobe)) begin
                    latch     = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (bank_mapped) begin
                    for (int b = 0; b < NBANK; b++) begin
                        if (bank_q == BANK_BITS'(b)) begin
                            WR[b] = dir_wr_q;
                            RD[b] = ~dir_wr_q;
                        end
                    end
                    if (sel_wait) begin
                        cnt_clr   = 1'b1;
                        state_nxt = ST_WAIT;
                    end else begin
                        ld        = 1'b1;
                        use_zero  = dir_wr_q;
                        state_nxt = ST_DONE;
                    end
                end else begin
                    ld          = 1'b1;
                    use_zero    = dir_wr_q;
                    use_err     = ~dir_wr_q;
                    err_ev      = 1'b1;
                    err_code_ev = ERR_UNMAP;
                    state_nxt   = ST_DONE;
                end
            end
            ST_WAIT: begin
                // Ready is checked first so a late answer on the last cycle is not an error.
                if (sel_rdy) begin
                    ld        = 1'b1;
                    use_zero  = dir_wr_q;
                    state_nxt = ST_DONE;
                end else if (cnt >= CW'(TIMEOUT - 1)) begin
                    ld          = 1'b1;
                    use_zero    = dir_wr_q;
                    use_err     = 1'b1;
                    err_ev      = 1'b1;
                    err_code_ev = ERR_TMO;
                    state_nxt   = ST_DONE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            ST_DONE: begin
                IO_Ready  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Transaction context and saturating wait counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            bank_q   <= '0;
            dir_wr_q <= 1'b0;
            cnt      <= '0;
        end else begin
            if (latch) begin
                bank_q   <= IO_Address[BANK_LSB +: BANK_BITS];
                dir_wr_q <= IO_Write_Strobe;
            end
            if (cnt_clr) begin
                cnt <= '0;
            end else if (cnt_inc && (cnt != CW'(TIMEOUT))) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Sticky error status: first error is kept; a new error beats a simultaneous clear.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ERR      <= 1'b0;
            ERR_CODE <= ERR_NONE;
            ERR_BANK <= '0;
        end else if (err_ev && (!ERR || ERR_CLR)) begin
            ERR      <= 1'b1;
            ERR_CODE <= err_code_ev;
            ERR_BANK <= bank_q;
        end else if (ERR_CLR && !err_ev) begin
            ERR      <= 1'b0;
            ERR_CODE <= ERR_NONE;
            ERR_BANK <= '0;
        end
    end

    busif_rdmux #(
        .NBANK     (NBANK),
        .BANK_BITS (BANK_BITS),
        .DW        (DW),
        .ERR_DATA  (ERR_DATA)
    ) u_rdmux (
        .CLK      (CLK),
        .RST      (RST),
        .ld       (ld),
        .sel      (bank_q),
        .use_err  (use_err),
        .use_zero (use_zero),
        .rdata    (RDATA),
        .dout     (IO_Read_Data)
    );

    assign BUSY      = (state != ST_IDLE);
    assign DBG_STATE = state;

endmodule

// File: tb/tb_busif_gen.sv
// Self-checking bench for busif_gen: directed cases plus randomized transactions
// compared against a transaction-level model of latency, strobes, data and errors.
module tb_busif_gen;

    localparam int               NBANK     = 8;
    localparam int               BANK_BITS = 4;
    localparam int               BANK_LSB  = 16;
    localparam int               DW        = 32;
    localparam logic [NBANK-1:0] WAITMASK  = 8'b0000_0001;
    localparam int               TIMEOUT   = 15;
    localparam logic [DW-1:0]    ERR_DATA  = 32'hDEAD_BEEF;

    logic                  CLK;
    logic                  RST;
    logic [31:0]           IO_Address;
    logic                  IO_Addr_Strobe;
    logic                  IO_Read_Strobe;
    logic                  IO_Write_Strobe;
    logic                  IO_Ready;
    logic [DW-1:0]         IO_Read_Data;
    logic [NBANK-1:0]      WR;
    logic [NBANK-1:0]      RD;
    logic [NBANK*DW-1:0]   RDATA;
    logic [NBANK-1:0]      BANK_RDY;
    logic                  ERR_CLR;
    logic                  ERR;
    logic [1:0]            ERR_CODE;
    logic [BANK_BITS-1:0]  ERR_BANK;
    logic                  BUSY;
    logic [1:0]            DBG_STATE;

    busif_gen #(
        .NBANK(NBANK), .BANK_BITS(BANK_BITS), .BANK_LSB(BANK_LSB), .DW(DW),
        .WAITMASK(WAITMASK), .TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)
    ) dut (
        .CLK(CLK), .RST(RST), .IO_Address(IO_Address), .IO_Addr_Strobe(IO_Addr_Strobe),
        .IO_Read_Strobe(IO_Read_Strobe), .IO_Write_Strobe(IO_Write_Strobe),
        .IO_Ready(IO_Ready), .IO_Read_Data(IO_Read_Data), .WR(WR), .RD(RD),
        .RDATA(RDATA), .BANK_RDY(BANK_RDY), .ERR_CLR(ERR_CLR), .ERR(ERR),
        .ERR_CODE(ERR_CODE), .ERR_BANK(ERR_BANK), .BUSY(BUSY), .DBG_STATE(DBG_STATE)
    );

    // Clock.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state: sticky error and last returned data.
    logic                 m_err;
    logic [1:0]           m_code;
    logic [BANK_BITS-1:0] m_bank;
    logic [DW-1:0]        m_data;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_err  = 1'b0;
        m_code = 2'b00;
        m_bank = '0;
        m_data = '0;
    endtask

    task automatic model_error(input logic [1:0] code, input int bank, input bit clr);
        if (!m_err || clr) begin
            m_err  = 1'b1;
            m_code = code;
            m_bank = BANK_BITS'(bank);
        end
    endtask

    // One transaction. d = WAIT cycles that see BANK_RDY low before it rises
    // (wait banks only). clr = pulse ERR_CLR during the strobe-out cycle.
    task automatic run_txn(input int bank, input bit is_wr, input int d,
                           input logic [DW-1:0] rdv, input bit clr);
        bit               mapped, waits, tmo;
        int               lat;
        logic [NBANK-1:0] onehot;
        logic [DW-1:0]    exp_data;
        mapped = (bank < NBANK);
        waits  = 1'b0;
        if (mapped) waits = WAITMASK[bank];
        tmo    = waits && (d >= TIMEOUT);
        lat    = !waits ? 2 : (tmo ? TIMEOUT + 2 : d + 3);
        onehot = mapped ? (NBANK'(1) << bank) : '0;

        for (int b = 0; b < NBANK; b++) RDATA[b*DW +: DW] = $urandom;
        if (mapped) RDATA[bank*DW +: DW] = rdv;

        if (is_wr) exp_data = '0;
        else if (!mapped || tmo) exp_data = ERR_DATA;
        else exp_data = rdv;

        // Model: clear in the strobe-out cycle, unmapped error in that same cycle,
        // timeout error at the end of the wait window.
        if (!mapped) model_error(2'b10, bank, clr);
        else if (clr) model_reset_err();
        if (tmo) model_error(2'b01, bank, 1'b0);
        m_data = exp_data;

        @(negedge CLK);
        IO_Address = $urandom;
        IO_Address[BANK_LSB +: BANK_BITS] = BANK_BITS'(bank);
        IO_Addr_Strobe  = 1'b1;
        IO_Write_Strobe = is_wr;
        IO_Read_Strobe  = !is_wr;
        BANK_RDY = waits ? (NBANK'($urandom) & ~onehot) : NBANK'($urandom);

        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge CLK);
            if (k <= lat) begin
                chk("busy", BUSY, 1'b1);
                chk("wr", WR, (k == 1 && is_wr) ? onehot : '0);
                chk("rd", RD, (k == 1 && !is_wr) ? onehot : '0);
                chk("ready", IO_Ready, k == lat);
            end
            if (k == lat) begin
                chk("data", IO_Read_Data, exp_data);
                chk("err", ERR, m_err);
                chk("err_code", ERR_CODE, m_code);
                chk("err_bank", ERR_BANK, m_bank);
            end
            if (k == lat + 1) begin
                chk("idle_busy", BUSY, 1'b0);
                chk("idle_ready", IO_Ready, 1'b0);
                chk("hold_data", IO_Read_Data, m_data);
            end
            IO_Addr_Strobe  = 1'b0;
            IO_Read_Strobe  = 1'b0;
            IO_Write_Strobe = 1'b0;
            ERR_CLR = (k == 1) && clr;
            if (waits) begin
                BANK_RDY = NBANK'($urandom) & ~onehot;
                if (k >= d + 2) BANK_RDY = BANK_RDY | onehot;
            end else begin
                BANK_RDY = NBANK'($urandom);
            end
        end
        BANK_RDY = '0;
        ERR_CLR  = 1'b0;
    endtask

    task automatic model_reset_err();
        m_err  = 1'b0;
        m_code = 2'b00;
        m_bank = '0;
    endtask

    task automatic clear_errors();
        @(negedge CLK);
        ERR_CLR = 1'b1;
        model_reset_err();
        @(negedge CLK);
        ERR_CLR = 1'b0;
        chk("clr_err", ERR, 1'b0);
        chk("clr_code", ERR_CODE, 2'b00);
        chk("clr_bank", ERR_BANK, 4'd0);
    endtask

    task automatic bad_strobe(input bit rd, input bit wr);
        @(negedge CLK);
        IO_Address = 32'hC005_0000;
        IO_Addr_Strobe  = 1'b1;
        IO_Read_Strobe  = rd;
        IO_Write_Strobe = wr;
        @(negedge CLK);
        IO_Addr_Strobe  = 1'b0;
        IO_Read_Strobe  = 1'b0;
        IO_Write_Strobe = 1'b0;
        chk("ignored_busy", BUSY, 1'b0);
        chk("ignored_wr", WR, '0);
        @(negedge CLK);
        chk("ignored_ready", IO_Ready, 1'b0);
    endtask

    initial begin
        bit saw_ready;
        int bank, d;
        bit is_wr, clr;

        // Reset.
        RST = 1'b1;
        IO_Address = '0;
        IO_Addr_Strobe = 1'b0;
        IO_Read_Strobe = 1'b0;
        IO_Write_Strobe = 1'b0;
        RDATA = '0;
        BANK_RDY = '0;
        ERR_CLR = 1'b0;
        model_reset();
        repeat (2) @(negedge CLK);
        chk("rst_ready", IO_Ready, 1'b0);
        chk("rst_data", IO_Read_Data, 32'h0);
        chk("rst_wr", WR, '0);
        chk("rst_rd", RD, '0);
        chk("rst_err", ERR, 1'b0);
        chk("rst_code", ERR_CODE, 2'b00);
        chk("rst_bank", ERR_BANK, 4'd0);
        chk("rst_busy", BUSY, 1'b0);
        RST = 1'b0;

        // Directed cases.
        run_txn(5, 1'b1, 0, 32'h0, 1'b0);
        run_txn(6, 1'b0, 0, 32'h1234_5678, 1'b0);
        run_txn(0, 1'b0, 6, 32'h0000_ABCD, 1'b0);
        run_txn(0, 1'b0, 99, 32'h5555_AAAA, 1'b0);
        run_txn(0, 1'b0, 99, 32'h5555_AAAA, 1'b0);
        run_txn(9, 1'b0, 0, 32'h0, 1'b0);
        clear_errors();
        run_txn(9, 1'b0, 0, 32'h0, 1'b0);
        run_txn(1, 1'b0, 0, 32'h0BAD_F00D, 1'b1);
        run_txn(12, 1'b1, 0, 32'h0, 1'b1);
        clear_errors();
        run_txn(0, 1'b0, TIMEOUT - 1, 32'hCAFE_0001, 1'b0);
        run_txn(0, 1'b1, TIMEOUT, 32'h0, 1'b0);
        clear_errors();
        bad_strobe(1'b1, 1'b1);
        bad_strobe(1'b0, 1'b0);

        // Reset during WAIT abandons the transaction.
        @(negedge CLK);
        IO_Address = 32'hC000_0000;
        IO_Addr_Strobe = 1'b1;
        IO_Read_Strobe = 1'b1;
        BANK_RDY = '0;
        @(negedge CLK);
        IO_Addr_Strobe = 1'b0;
        IO_Read_Strobe = 1'b0;
        repeat (4) @(negedge CLK);
        RST = 1'b1;
        model_reset();
        @(negedge CLK);
        RST = 1'b0;
        chk("rst_wait_busy", BUSY, 1'b0);
        chk("rst_wait_data", IO_Read_Data, 32'h0);
        saw_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            saw_ready = saw_ready | IO_Ready;
            BANK_RDY = '1;
        end
        BANK_RDY = '0;
        chk("rst_no_ready", saw_ready, 1'b0);
        run_txn(5, 1'b1, 0, 32'h0, 1'b0);

        // Randomized transactions.
        for (int n = 0; n < 40; n++) begin
            bank  = $urandom_range(0, 11);
            is_wr = $urandom_range(0, 1);
            d     = $urandom_range(0, TIMEOUT + 3);
            clr   = ($urandom_range(0, 3) == 0);
            if (m_err && bank >= NBANK) clr = 1'b0;
            run_txn(bank, is_wr, d, $urandom, clr);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
